// File: rtl/scram_arbiter.sv
// scram_arbiter: round-robin arbiter sharing one scratch-RAM port between
// NREQ requesters, one transaction at a time, with an IDLE gap after each.
// Optional build macro SCRAM_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins, pointer held at 0); default build is round-robin.
module scram_arbiter #(
  parameter int unsigned ADDRW = 4,
  parameter int unsigned DATAW = 16,
  parameter int unsigned NREQ  = 2
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NREQ-1:0]         req_en,
  input  logic [NREQ-1:0]         req_wr,
  input  logic [NREQ*ADDRW-1:0]   req_addr,
  input  logic [NREQ*DATAW-1:0]   req_wdata,
  input  logic [NREQ*DATAW/8-1:0] req_strb,
  output logic [DATAW-1:0]        req_rdata,
  output logic [NREQ-1:0]         req_ready,
  output logic                    mem_en,
  output logic                    mem_wr,
  output logic [ADDRW-1:0]        mem_addr,
  output logic [DATAW-1:0]        mem_wdata,
  output logic [DATAW/8-1:0]      mem_strb,
  input  logic [DATAW-1:0]        mem_rdata,
  input  logic                    mem_ready,
  output logic [NREQ-1:0]         grant,
  output logic                    busy
);

  localparam int unsigned STRBW = DATAW / 8;
  localparam int unsigned PTRW  = (NREQ > 2) ? 2 : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]      r_state;
  logic [NREQ-1:0] r_grant;
  logic [PTRW-1:0] r_gidx;
  logic [PTRW-1:0] r_ptr;

  logic [0:0]      w_nxt_state;
  logic [NREQ-1:0] w_nxt_grant;
  logic [PTRW-1:0] w_nxt_gidx;
  logic [PTRW-1:0] w_nxt_ptr;

  logic            w_win_found;
  logic [PTRW-1:0] w_win_idx;
  logic [PTRW-1:0] w_scan;
  logic [PTRW-1:0] w_ptr_inc;
  logic            w_gnt_en;

  // Round-robin scan starting at the priority pointer; in the fixed-priority
  // build the pointer stays at 0 so this degenerates to lowest-index-wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_scan      = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_scan = PTRW'((32'(r_ptr) + 32'(k)) % NREQ);
      if (!w_win_found && req_en[w_scan]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_scan;
      end
    end
  end

  // Pointer value after a completed transaction: one past the granted requester.
  always_comb begin
    w_ptr_inc = (r_gidx == PTRW'(NREQ - 1)) ? '0 : r_gidx + PTRW'(1);
  end

  // Granted requester still asserting its request (abort detection).
  always_comb begin
    w_gnt_en = |(req_en & r_grant);
  end

  // State register and arbitration bookkeeping.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_grant <= w_nxt_grant;
      r_gidx  <= w_nxt_gidx;
      r_ptr   <= w_nxt_ptr;
    end
  end

  // Next-state logic: arbitrate in IDLE, return to IDLE on completion or abort.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = r_grant;
    w_nxt_gidx  = r_gidx;
    w_nxt_ptr   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_nxt_state            = S_BUSY;
          w_nxt_grant            = '0;
          w_nxt_grant[w_win_idx] = 1'b1;
          w_nxt_gidx             = w_win_idx;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          w_nxt_state = S_IDLE;
          w_nxt_grant = '0;
`ifdef SCRAM_ARB_FIXED_PRIO_EN
          w_nxt_ptr   = '0;
`else
          w_nxt_ptr   = w_ptr_inc;
`endif
        end else if (!w_gnt_en) begin
          w_nxt_state = S_IDLE;
          w_nxt_grant = '0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_grant = '0;
      end
    endcase
  end

  // RAM port mux from the granted requester; quiet whenever IDLE.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_strb  = '0;
    req_ready = '0;
    if (r_state == S_BUSY) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (r_grant[i]) begin
          mem_en       = req_en[i];
          mem_wr       = req_wr[i];
          mem_addr     = req_addr[i*ADDRW +: ADDRW];
          mem_wdata    = req_wdata[i*DATAW +: DATAW];
          mem_strb     = req_strb[i*STRBW +: STRBW];
          req_ready[i] = mem_ready;
        end
      end
    end
  end

  assign req_rdata = mem_rdata;
  assign grant     = r_grant;
  assign busy      = (r_state == S_BUSY);

endmodule

// File: tb/tb_scram_arbiter.sv
// Directed bench for scram_arbiter (NREQ=2, ADDRW=4, DATAW=16) with a small
// behavioural RAM: writes complete same cycle, reads one cycle after en.
module tb_scram_arbiter;

  localparam int unsigned ADDRW = 4;
  localparam int unsigned DATAW = 16;
  localparam int unsigned NREQ  = 2;

  logic        aclk = 1'b0;
  logic        areset;
  logic [1:0]  req_en, req_wr;
  logic [3:0]  addr0, addr1;
  logic [15:0] wd0, wd1;
  logic [1:0]  st0, st1;
  logic [15:0] req_rdata;
  logic [1:0]  req_ready;
  logic        mem_en, mem_wr;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_strb;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [1:0]  grant;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  scram_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW), .NREQ(NREQ)) dut (
    .aclk(aclk), .areset(areset),
    .req_en(req_en), .req_wr(req_wr),
    .req_addr({addr1, addr0}), .req_wdata({wd1, wd0}), .req_strb({st1, st0}),
    .req_rdata(req_rdata), .req_ready(req_ready),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .busy(busy)
  );

  always #5 aclk = ~aclk;

  // RAM model
  logic [15:0] ram [16];
  logic        r_pend;
  assign mem_ready = mem_en & (mem_wr | r_pend);

  always @(posedge aclk or posedge areset) begin
    if (areset) r_pend <= 1'b0;
    else        r_pend <= mem_en & ~mem_wr & ~mem_ready;
  end

  always @(posedge aclk) begin
    if (mem_en && mem_wr) begin
      if (mem_strb[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
      if (mem_strb[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
    end
    if (mem_en && !mem_wr) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

`ifdef SCRAM_ARB_FIXED_PRIO_EN
  localparam logic [1:0] G2 = 2'b01;
`else
  localparam logic [1:0] G2 = 2'b10;
`endif

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 16'h0000;
    mem_rdata = '0;
    areset = 1'b1;
    req_en = '0; req_wr = '0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0; st0 = '0; st1 = '0;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_ready", 32'(req_ready), 0);
    areset = 1'b0;

    // single write: req0 addr 3 <= BEEF
    req_en = 2'b01; req_wr = 2'b01; addr0 = 4'd3; wd0 = 16'hBEEF; st0 = 2'b11;
    #1 chk("wr_idle_grant", 32'(grant), 0);
    tick();
    chk("wr_grant", 32'(grant), 32'h1);
    chk("wr_busy", 32'(busy), 1);
    chk("wr_mem_en", 32'(mem_en), 1);
    chk("wr_mem_wr", 32'(mem_wr), 1);
    chk("wr_addr", 32'(mem_addr), 3);
    chk("wr_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("wr_ready", 32'(req_ready), 32'h1);
    tick();
    chk("wr_post_busy", 32'(busy), 0);
    chk("wr_post_grant", 32'(grant), 0);
    chk("wr_post_ready", 32'(req_ready), 0);
    req_en = 2'b00;

    // read back addr 3 by req0 (ptr now 1, only req0 requesting)
    tick();
    req_en = 2'b01; req_wr = 2'b00;
    tick();
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_ready_early", 32'(req_ready), 0);
    chk("rd_mem_wr", 32'(mem_wr), 0);
    tick();
    chk("rd_ready", 32'(req_ready), 32'h1);
    chk("rd_data", 32'(req_rdata), 32'hBEEF);
    tick();
    req_en = 2'b00;

    // strobes: req1 writes FFFF then 1234 with strb 01 to addr 5, reads back
    addr1 = 4'd5; wd1 = 16'hFFFF; st1 = 2'b11; req_wr = 2'b10; req_en = 2'b10;
    tick();
    chk("sb_grant1", 32'(grant), 32'h2);
    chk("sb_ready1", 32'(req_ready), 32'h2);
    tick(); req_en = 2'b00;
    wd1 = 16'h1234; st1 = 2'b01; req_en = 2'b10;
    tick();
    chk("sb_strb", 32'(mem_strb), 32'h1);
    chk("sb_ready2", 32'(req_ready), 32'h2);
    tick(); req_en = 2'b00;
    req_wr = 2'b00; req_en = 2'b10;
    tick(); tick();
    chk("sb_rd_ready", 32'(req_ready), 32'h2);
    chk("sb_rd_data", 32'(req_rdata), 32'hFF34);
    tick(); req_en = 2'b00;

    // move pointer to 1 with a req0 write to addr 0
    addr0 = 4'd0; wd0 = 16'h0000; st0 = 2'b00; req_wr = 2'b01; req_en = 2'b01;
    tick(); tick(); req_en = 2'b00; req_wr = 2'b00;

    // abort: both request, req1 wins (ptr=1), then drops before mem_ready
    addr0 = 4'd3; req_en = 2'b11;
    tick();
    chk("ab_grant", 32'(grant), 32'h2);
    req_en = 2'b01;
    #1 chk("ab_mem_en", 32'(mem_en), 0);
    chk("ab_ready", 32'(req_ready), 0);
    tick();
    chk("ab_idle_busy", 32'(busy), 0);
    chk("ab_idle_grant", 32'(grant), 0);
    chk("ab_idle_ready", 32'(req_ready), 0);
    req_en = 2'b11;
    tick();
    chk("ab_keep_prio", 32'(grant), 32'h2);
    tick();
    chk("ab_rd_ready", 32'(req_ready), 32'h2);
    chk("ab_rd_data", 32'(req_rdata), 32'hFF34);
    tick(); req_en = 2'b00;

    // contention from reset: both read continuously
    areset = 1'b1; #1 areset = 1'b0;
    req_en = 2'b11;
    tick();
    chk("ct_g1", 32'(grant), 32'h1);
    tick();
    chk("ct_r1", 32'(req_ready), 32'h1);
    chk("ct_d1", 32'(req_rdata), 32'hBEEF);
    tick();
    chk("ct_gap1", 32'(req_ready), 0);
    chk("ct_gap1_grant", 32'(grant), 0);
    tick();
    chk("ct_g2", 32'(grant), 32'(G2));
    tick();
    chk("ct_r2", 32'(req_ready), 32'(G2));
    tick();
    chk("ct_gap2", 32'(req_ready), 0);
    tick();
    chk("ct_g3", 32'(grant), 32'h1);
    tick(); tick();
    tick();
    chk("ct_g4", 32'(grant), 32'(G2));
    chk("ct_g4_busy", 32'(busy), 1);

    // reset pulsed during BUSY
    areset = 1'b1;
    #1 chk("mr_mem_en", 32'(mem_en), 0);
    chk("mr_grant", 32'(grant), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_ready", 32'(req_ready), 0);
    areset = 1'b0;
    tick();
    chk("mr_restart", 32'(grant), 32'h1);
    tick();
    chk("mr_ready2", 32'(req_ready), 32'h1);
    req_en = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scram_arbiter.md
SCRAM_ARBITER -- requirements
Module: scram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRW, default 4, the RAM word-address width.
REQ-002 The block SHALL have parameter DATAW, default 16, the data width; DATAW SHALL be a multiple of 8.
REQ-003 The block SHALL have parameter NREQ, default 2, the number of requesters, legal range 2..4.
REQ-004 The block SHALL have one clock and an asynchronous active-high reset, named aclk and areset as the codebase does.
REQ-005 Ports SHALL be:
- aclk  in  1  clock
- areset  in  1  async active-high reset
- req_en  in  NREQ  per-requester access request
- req_wr  in  NREQ  1=write, 0=read
- req_addr  in  NREQ*ADDRW  packed addresses, requester i at [i*ADDRW+:ADDRW]
- req_wdata  in  NREQ*DATAW  packed write data
- req_strb  in  NREQ*DATAW/8  packed byte strobes
- req_rdata  out  DATAW  read data, broadcast to all requesters
- req_ready  out  NREQ  per-requester completion
- mem_en  out  1  RAM port enable
- mem_wr  out  1  RAM write
- mem_addr  out  ADDRW  RAM address
- mem_wdata  out  DATAW  RAM write data
- mem_strb  out  DATAW/8  RAM byte strobes
- mem_rdata  in  DATAW  RAM read data
- mem_ready  in  1  RAM completion: same cycle for writes, one cycle after en for reads
- grant  out  NREQ  one-hot owner of the RAM port, 0 when idle
- busy  out  1  1 when in BUSY

Function
REQ-006 The block SHALL share one scram port between NREQ requesters, one transaction at a time.
REQ-007 A requester SHALL hold req_en and its address, data, strobe and wr stable until its req_ready; the block relies on this.
REQ-008 The FSM SHALL have two states: IDLE and BUSY.
REQ-009 In IDLE with any req_en set: select a winner, register grant one-hot, and enter BUSY on the next edge.
REQ-010 In IDLE with no req_en set: the state, grant and priority pointer SHALL be unchanged.
REQ-011 In IDLE: mem_en=0, req_ready=0 and grant=0.
REQ-012 Winner selection, round-robin: scan from priority pointer ptr upward, modulo NREQ; the first requester with req_en set wins.
REQ-013 In BUSY, mem_en, mem_wr, mem_addr, mem_wdata and mem_strb SHALL be combinationally muxed from the granted requester, with mem_en = req_en[granted].
REQ-014 In BUSY, req_ready[granted] = mem_ready; all other req_ready bits SHALL be 0.
REQ-015 req_rdata SHALL be mem_rdata, passed through combinationally.
REQ-016 In BUSY with mem_ready=1: next state IDLE, grant cleared, ptr = granted index + 1 modulo NREQ.
REQ-017 In BUSY, if req_en[granted] drops before mem_ready (abort): next state IDLE, grant cleared, ptr unchanged, no req_ready issued.
REQ-018 Every transaction SHALL be followed by at least one IDLE cycle, so the RAM read-ready toggle re-arms.
REQ-019 Latency from req_en to req_ready SHALL be 1 cycle for a write and 2 cycles for a read, when the RAM port is free.
REQ-020 Requests that rise while BUSY SHALL wait; they are never dropped and are served in pointer order.
REQ-021 With NREQ requesters continuously requesting, each requester SHALL be granted within NREQ transactions (no starvation in round-robin mode).

Reset
REQ-022 areset asserted SHALL asynchronously force: state IDLE, grant=0, ptr=0, busy=0, mem_en=0, req_ready=0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction with no req_ready.
REQ-024 After reset release, arbitration SHALL restart from requester 0.

Configuration
REQ-025 Macro SCRAM_ARB_FIXED_PRIO_EN defined: winner SHALL be the lowest index with req_en set, and ptr SHALL be held at 0.
REQ-026 Macro SCRAM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-012 and REQ-016 SHALL apply.
REQ-027 The interface and latency SHALL be identical in both builds.

Verification
REQ-028 Single write: req 0 writes addr 3, data 0xBEEF, strb 2'b11 -> req_ready[0] high 1 cycle after req_en; a read of addr 3 then returns 0xBEEF with req_ready 2 cycles after req_en.
REQ-029 Contention, round-robin: req 0 and req 1 both read continuously from reset -> grant sequence 01,10,01,10; each req_ready pulse is 1 cycle wide.
REQ-030 Same stimulus as REQ-029 with SCRAM_ARB_FIXED_PRIO_EN defined -> grant stays 01 while req 0 holds req_en; req 1 is served only after req 0 drops.
REQ-031 Abort: req 1 granted for a read and drops req_en before mem_ready -> IDLE next cycle, req_ready=0, ptr unchanged (req 1 keeps priority).
REQ-032 Reset mid-read: areset pulsed in the BUSY cycle -> mem_en, grant and busy are 0 immediately; the first request after release is granted to req 0.
REQ-033 Byte strobes: req 1 writes 0x1234 with strb 2'b01 over 0xFFFF -> a subsequent read returns 0xFF34.
